// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types for the memory scan engine: FSM state encoding
//               and the {address, data} pair carried through the skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int SCAN_ADDR_W = 32;
    localparam int SCAN_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic [SCAN_ADDR_W-1:0] addr;
        logic [SCAN_DATA_W-1:0] data;
    } scan_pair_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/scan_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : scan_skid_buf
// Description : Small synchronous FIFO holding returned {addr, data} pairs.
//               Head entry is presented combinationally; flush empties it in
//               one cycle. The upstream credit check guarantees no overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_skid_buf
    import scan_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = scan_pair_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  ENTRY_T           push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output ENTRY_T           head_o
);

    ENTRY_T             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : scan_skid_buf
`default_nettype wire

// File: rtl/mem_scan_engine.sv
`default_nettype none
// ============================================================================
// Module      : mem_scan_engine
// Description : Walks a synchronous single-port RAM over [start, end] with a
//               programmable stride and streams {addr, data} pairs out over a
//               valid/ready interface, one pair per cycle when unstalled.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_scan_engine
    import scan_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              aborted_o,
    output logic [ADDR_W-1:0] words_sent_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    // Pair type sized to this instance (the package type is fixed at defaults).
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pair_t;

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              inflight_q;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;

    logic [CNT_W-1:0]  count;
    pair_t             head;
    pair_t             push_data;
    logic              active;
    logic              push;
    logic              pop;
    logic              credit;
    logic              issue;
    logic              last_rd;
    logic [ADDR_W:0]   nxt_sum;

    // Datapath strobes: issue gating by credit, capture of returned reads, handshake.
    always_comb begin
        active         = (state_q == RUN) || (state_q == DRAIN);
        out_valid_o    = (count != '0);
        pop            = out_valid_o && out_ready_i;
        // An abort discards the read currently returning from the RAM.
        push           = inflight_q && active && !abort_i;
        // Occupancy plus the outstanding read, less this cycle's pop, must leave a slot.
        credit         = (int'(count) + int'(inflight_q)) < (BUF_DEPTH + int'(pop));
        issue          = (state_q == RUN) && !abort_i && credit;
        // Extra top bit catches a carry out of the address space.
        nxt_sum        = {1'b0, cur_q} + {1'b0, stride_q};
        last_rd        = nxt_sum[ADDR_W] || (nxt_sum[ADDR_W-1:0] > end_q);
        push_data.addr = rd_addr_q;
        push_data.data = mem_rdata_i;
    end

    scan_skid_buf #(
        .DEPTH   (BUF_DEPTH),
        .ENTRY_T (pair_t)
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (active && abort_i),
        .count_o     (count),
        .head_o      (head)
    );

    // Next-state logic for the scan FSM and its configuration/status registers.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        end_d     = end_q;
        stride_d  = stride_q;
        err_d     = err_q;
        aborted_d = aborted_q;
        words_d   = words_q + ADDR_W'(pop);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_d     = start_addr_i;
                    end_d     = end_addr_i;
                    stride_d  = stride_i;
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    words_d   = '0;
                    if ((stride_i == '0) || (end_addr_i < start_addr_i)) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (issue) begin
                    cur_d = nxt_sum[ADDR_W-1:0];
                    if (last_rd) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (!inflight_q &&
                             ((count == '0) || ((count == CNT_W'(1)) && pop))) begin
                    // Leave as the final pair is accepted so done lands one cycle later.
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, configuration and read-tracking registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            end_q      <= '0;
            stride_q   <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            inflight_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            end_q      <= end_d;
            stride_q   <= stride_d;
            words_q    <= words_d;
            err_q      <= err_d;
            aborted_q  <= aborted_d;
            inflight_q <= issue;
            if (issue) begin
                rd_addr_q <= cur_q;
            end
        end
    end

    assign mem_rd_en_o  = issue;
    assign mem_addr_o   = cur_q;
    assign out_addr_o   = head.addr;
    assign out_data_o   = head.data;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == FINISH);
    assign err_o        = err_q;
    assign aborted_o    = aborted_q;
    assign words_sent_o = words_q;

endmodule : mem_scan_engine
`default_nettype wire

// File: doc/mem_scan_engine.md
# mem_scan_engine

Hardware successor to bench-side memory dumps: walks a synchronous single-port RAM over a programmable address window (start, inclusive end, stride) and streams {address, data} pairs out over a valid/ready interface. It sits between a control source (debug/test controller or CPU MMIO) and a data memory read port. It hides the RAM's 1-cycle read latency behind a small skid buffer, so it sustains one word per cycle under back-pressure.

## Interface
- ADDR_W, 32, address width (byte addresses)
- DATA_W, 32, RAM word width
- BUF_DEPTH, 2, output buffer entries; legal range ≥2, power of two
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  cancel scan; honoured in RUN and DRAIN
- start_addr  in  ADDR_W  first address
- end_addr  in  ADDR_W  last allowed address, inclusive
- stride  in  ADDR_W  address increment
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  DATA_W  RAM data, valid the cycle after mem_rd_en
- out_valid  out  1  pair available
- out_ready  in  1  sink accepts pair
- out_addr  out  ADDR_W  address of out_data
- out_data  out  DATA_W  word read
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at scan end (normal, error or abort)
- err  out  1  done qualifier: illegal config; held until next start
- aborted  out  1  done qualifier: scan aborted; held until next start
- words_sent  out  ADDR_W  pairs transferred in current/last scan

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE + start: latch start_addr/end_addr/stride and clear err, aborted and words_sent.
  - If stride==0 or end_addr<start_addr (unsigned): set err and go to FINISH. No RAM read is issued.
  - Otherwise go to RUN with cur=start_addr.
- RUN issues a read (mem_rd_en=1, mem_addr=cur) when occupancy+inflight−pop < BUF_DEPTH. inflight is 0/1, a registered copy of mem_rd_en. On issue, cur += stride.
- Last read: the issue where cur+stride exceeds end_addr or carries out of ADDR_W. That issue moves the FSM to DRAIN. No wrap-around read is ever issued.
- DRAIN: wait until inflight==0 and buffer empty, then go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Capture: each returned mem_rdata is pushed with its address (registered alongside the read) into the buffer. Buffer head drives out_*.
- Transfer: out_valid&&out_ready pops one entry and increments words_sent.
- abort in RUN/DRAIN:
  - stop issuing immediately;
  - discard the in-flight read and flush the buffer (out_valid=0 next cycle);
  - set aborted, go to FINISH.
  - words_sent keeps its count.
  - abort in IDLE or FINISH is ignored.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins.

## Timing
- Reset values: state IDLE; mem_rd_en=0, mem_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, err=0, aborted=0, words_sent=0; buffer empty; inflight=0.
- Reset asserted mid-scan: all of the above immediately (asynchronous), and the scan is lost.
- start sampled at edge E0:
  - busy=1 and first mem_rd_en in cycle 1;
  - mem_rdata in cycle 2;
  - out_valid in cycle 3.
- Throughput with out_ready=1 is one pair per cycle. N-word scan: done pulses in cycle N+3.
- Error path: done pulses in cycle 1 with err=1.
- out_valid, once high, holds with stable out_addr/out_data until accepted (AXI-style). out_valid never depends combinationally on out_ready.
- Buffer never overflows. The credit rule guarantees space for every in-flight read.

## Structure
- Package scan_pkg holds:
  - enum scan_state_t {IDLE, RUN, DRAIN, FINISH};
  - a packed struct scan_pair_t {addr, data} (parametrised through localparams matching the defaults).
- Sub-module scan_skid_buf: synchronous FIFO of scan_pair_t, depth BUF_DEPTH. Ports: push, pop, flush, count, head. Same clk/reset.
- Top holds the FSM, address generator with carry detect, inflight flag and words_sent counter.

## Test plan
- start=0, end=104, stride=4, out_ready=1, RAM word k = 0xA000+k:
  - 27 pairs with out_addr 0,4,…,104 and data 0xA000…0xA01A;
  - one pair per cycle; done in cycle 30; words_sent=27.
- Same scan with out_ready toggling 1-0-1-1-0 pseudo-randomly → identical ordered 27 pairs, no drop or duplicate, out_* stable while stalled.
- stride=0 or start=8, end=4 → no mem_rd_en; done next cycle with err=1; words_sent=0.
- ADDR_W=8, start=0xF8, end=0xFF, stride=4 → exactly pairs 0xF8, 0xFC; no read at 0x00.
- abort after 5 pairs accepted in the 27-word scan → mem_rd_en low next cycle, out_valid low next cycle, done with aborted=1, words_sent=5; a following start runs cleanly.
- reset low mid-scan → all outputs at reset values in the same cycle; after release, start yields a correct fresh scan.
